// File: rtl/riscv_definitions_pkg.sv
// Shared RISC-V datapath types used by the operand-fetch slice.
package riscv_definitions;

  localparam int unsigned XLEN   = 32;
  localparam int unsigned REG_AW = 5;

  typedef logic [REG_AW-1:0] regAddr_t;

  typedef union packed {
    logic        [XLEN-1:0] u;
    logic signed [XLEN-1:0] s;
  } dataBus_u;

  typedef enum logic [2:0] {
    FWD_RF,
    FWD_EX,
    FWD_MEM,
    FWD_WB,
    FWD_ZERO
  } fwdSel_t;

  // A stage tap matches when it writes a register and the indices agree.
  function automatic logic tap_hit(input regAddr_t addr, input regAddr_t rd,
                                   input logic wr_en);
    return wr_en && (addr == rd);
  endfunction

endpackage

// File: rtl/operand_fetch_fwd_mux.sv
// Per-operand bypass selector: x0, then EX, MEM, WB, then register file.
module fwd_mux
  import riscv_definitions::*;
#(
  parameter bit FWD_EN = 1'b1
) (
  input  regAddr_t addr,
  input  dataBus_u rf_data,
  input  regAddr_t ex_rd_addr,
  input  logic     ex_rd_wr_en,
  input  logic     ex_is_load,
  input  dataBus_u ex_result,
  input  regAddr_t mem_rd_addr,
  input  logic     mem_rd_wr_en,
  input  dataBus_u mem_result,
  input  regAddr_t wb_rd_addr,
  input  logic     wb_rd_wr_en,
  input  dataBus_u wb_data,
  output dataBus_u data,
  output fwdSel_t  sel
);

  // Priority select; a load in EX has no result yet so it is skipped here.
  always_comb begin
    sel  = FWD_RF;
    data = rf_data;
    if (addr == '0) begin
      sel  = FWD_ZERO;
      data = '0;
    end else if (FWD_EN) begin
      if (tap_hit(addr, ex_rd_addr, ex_rd_wr_en) && !ex_is_load) begin
        sel  = FWD_EX;
        data = ex_result;
      end else if (tap_hit(addr, mem_rd_addr, mem_rd_wr_en)) begin
        sel  = FWD_MEM;
        data = mem_result;
      end else if (tap_hit(addr, wb_rd_addr, wb_rd_wr_en)) begin
        sel  = FWD_WB;
        data = wb_data;
      end
    end
  end

endmodule

// File: rtl/operand_fetch.sv
// ID-side operand stage: bypass muxes, load-use hazard detect, ID/EX register.
module operand_fetch
  import riscv_definitions::*;
#(
  parameter bit FWD_EN = 1'b1
) (
  input  logic     clk,
  input  logic     clk_en,
  input  logic     rst_n,
  input  logic     id_valid,
  input  regAddr_t id_rs1_addr,
  input  regAddr_t id_rs2_addr,
  input  logic     id_rs1_used,
  input  logic     id_rs2_used,
  input  regAddr_t id_rd_addr,
  input  dataBus_u rf_rs1,
  input  dataBus_u rf_rs2,
  input  regAddr_t ex_rd_addr,
  input  logic     ex_rd_wr_en,
  input  logic     ex_is_load,
  input  dataBus_u ex_result,
  input  regAddr_t mem_rd_addr,
  input  logic     mem_rd_wr_en,
  input  dataBus_u mem_result,
  input  regAddr_t wb_rd_addr,
  input  logic     wb_rd_wr_en,
  input  dataBus_u wb_data,
  input  logic     ex_hold,
  input  logic     flush,
  output logic     stall_id,
  output logic     idex_valid,
  output dataBus_u idex_rs1,
  output dataBus_u idex_rs2,
  output regAddr_t idex_rd_addr
);

  dataBus_u w_rs1_fwd;
  dataBus_u w_rs2_fwd;
  fwdSel_t  w_rs1_sel_unused;  // exposed for coverage probes
  fwdSel_t  w_rs2_sel_unused;
  logic     w_load_use;

  logic     r_idex_valid;
  dataBus_u r_idex_rs1;
  dataBus_u r_idex_rs2;
  regAddr_t r_idex_rd_addr;

  fwd_mux #(.FWD_EN(FWD_EN)) u_fwd_rs1 (
    .addr         (id_rs1_addr),
    .rf_data      (rf_rs1),
    .ex_rd_addr   (ex_rd_addr),
    .ex_rd_wr_en  (ex_rd_wr_en),
    .ex_is_load   (ex_is_load),
    .ex_result    (ex_result),
    .mem_rd_addr  (mem_rd_addr),
    .mem_rd_wr_en (mem_rd_wr_en),
    .mem_result   (mem_result),
    .wb_rd_addr   (wb_rd_addr),
    .wb_rd_wr_en  (wb_rd_wr_en),
    .wb_data      (wb_data),
    .data         (w_rs1_fwd),
    .sel          (w_rs1_sel_unused)
  );

  fwd_mux #(.FWD_EN(FWD_EN)) u_fwd_rs2 (
    .addr         (id_rs2_addr),
    .rf_data      (rf_rs2),
    .ex_rd_addr   (ex_rd_addr),
    .ex_rd_wr_en  (ex_rd_wr_en),
    .ex_is_load   (ex_is_load),
    .ex_result    (ex_result),
    .mem_rd_addr  (mem_rd_addr),
    .mem_rd_wr_en (mem_rd_wr_en),
    .mem_result   (mem_result),
    .wb_rd_addr   (wb_rd_addr),
    .wb_rd_wr_en  (wb_rd_wr_en),
    .wb_data      (wb_data),
    .data         (w_rs2_fwd),
    .sel          (w_rs2_sel_unused)
  );

  // Load-use: a used source waits on a load still in EX; one bubble suffices.
  always_comb begin
    w_load_use = id_valid && ex_is_load && ex_rd_wr_en && (ex_rd_addr != '0) &&
                 ((id_rs1_used && (id_rs1_addr == ex_rd_addr)) ||
                  (id_rs2_used && (id_rs2_addr == ex_rd_addr)));
    stall_id   = w_load_use || ex_hold;
  end

  // ID/EX boundary: flush > hold > bubble > capture.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_idex_valid   <= 1'b0;
      r_idex_rs1     <= '0;
      r_idex_rs2     <= '0;
      r_idex_rd_addr <= '0;
    end else if (clk_en) begin
      if (flush) begin
        r_idex_valid <= 1'b0;
      end else if (ex_hold) begin
        r_idex_valid <= r_idex_valid;
      end else if (w_load_use) begin
        r_idex_valid <= 1'b0;
      end else begin
        r_idex_valid   <= id_valid;
        r_idex_rs1     <= w_rs1_fwd;
        r_idex_rs2     <= w_rs2_fwd;
        r_idex_rd_addr <= id_rd_addr;
      end
    end
  end

  assign idex_valid   = r_idex_valid;
  assign idex_rs1     = r_idex_rs1;
  assign idex_rs2     = r_idex_rs2;
  assign idex_rd_addr = r_idex_rd_addr;

endmodule
